// File: rtl/phase_scheduler.sv
// Four-approach signal-phase scheduler: round-robin demand arbitration with min/max
// green, yellow and all-red clearance, plus emergency preemption.
module phase_scheduler #(
   parameter int unsigned GREEN_MIN = 3,
   parameter int unsigned GREEN_MAX = 7,
   parameter int unsigned YELLOW_T  = 2,
   parameter int unsigned ALLRED_T  = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick,
   input  logic [3:0] req,
   input  logic       emg_req,
   input  logic [1:0] emg_dir,
   output logic [2:0] m1,
   output logic [2:0] m2,
   output logic [2:0] m3,
   output logic [2:0] m4,
   output logic [3:0] grant,
   output logic       emg_active,
   output logic [2:0] dbg_state
);

   typedef enum logic [2:0] {IDLE, GREEN, YELLOW, ALLRED, EMG_GREEN} state_t;

   localparam logic [4:0] G_MIN = 5'(GREEN_MIN);
   localparam logic [4:0] G_MAX = 5'(GREEN_MAX);
   localparam logic [4:0] Y_LEN = 5'(YELLOW_T);
   localparam logic [4:0] A_LEN = 5'(ALLRED_T);
   localparam logic [2:0] LT_G  = 3'b001;
   localparam logic [2:0] LT_Y  = 3'b010;
   localparam logic [2:0] LT_R  = 3'b100;

   state_t      state, state_n;
   logic [3:0]  cnt, cnt_n;
   logic [1:0]  cur, cur_n;
   logic [1:0]  ptr, ptr_n;
   logic        emg_n;
   logic [4:0]  e;
   logic        found;
   logic [1:0]  pick, idx;
   logic [3:0]  cur_oh;
   logic [11:0] lights_n;
   logic [3:0]  grant_n;

   assign dbg_state = state;
   assign e         = {1'b0, cnt} + 5'd1;
   assign cur_oh    = 4'b0001 << cur;

   // Round-robin search starting at ptr and wrapping mod 4.
   always_comb begin
      found = 1'b0;
      pick  = ptr;
      idx   = ptr;
      for (int i = 0; i < 4; i++) begin
         idx = ptr + 2'(i);
         if (!found && req[idx]) begin
            found = 1'b1;
            pick  = idx;
         end
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      cur_n   = cur;
      ptr_n   = ptr;
      emg_n   = emg_active;
      case (state)
         IDLE: begin
            if (emg_req) begin
               cur_n   = emg_dir;
               emg_n   = 1'b1;
               cnt_n   = '0;
               state_n = EMG_GREEN;
            end else if (found) begin
               cur_n   = pick;
               ptr_n   = pick + 2'd1;
               cnt_n   = '0;
               state_n = GREEN;
            end
         end
         GREEN: begin
            // Preemption is evaluated every clock and overrides the tick rules.
            if (emg_req) begin
               emg_n   = 1'b1;
               cnt_n   = '0;
               state_n = (emg_dir == cur) ? EMG_GREEN : YELLOW;
            end else if (tick) begin
               cnt_n = e[3:0];
               if (e >= G_MAX ||
                   (e >= G_MIN && (((req & ~cur_oh) != 4'd0) || !req[cur]))) begin
                  cnt_n   = '0;
                  state_n = YELLOW;
               end
            end
         end
         EMG_GREEN: begin
            if (!emg_req) begin
               cnt_n   = '0;
               state_n = YELLOW;
            end
         end
         YELLOW: begin
            if (tick) begin
               cnt_n = e[3:0];
               if (e == Y_LEN) begin
                  cnt_n   = '0;
                  state_n = ALLRED;
               end
            end
         end
         ALLRED: begin
            if (tick) begin
               cnt_n = e[3:0];
               if (e == A_LEN) begin
                  cnt_n   = '0;
                  emg_n   = emg_active & emg_req;
                  state_n = IDLE;
               end
            end
         end
         default: begin
            cnt_n   = '0;
            state_n = IDLE;
         end
      endcase
   end

   // Light codes are decoded from the state being entered so they register with it.
   always_comb begin
      lights_n = {4{LT_R}};
      grant_n  = '0;
      for (int k = 0; k < 4; k++) begin
         if (2'(k) == cur_n) begin
            if (state_n == GREEN || state_n == EMG_GREEN) begin
               lights_n[3*k +: 3] = LT_G;
               grant_n[k]         = 1'b1;
            end else if (state_n == YELLOW) begin
               lights_n[3*k +: 3] = LT_Y;
               grant_n[k]         = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         cnt        <= '0;
         cur        <= '0;
         ptr        <= '0;
         emg_active <= 1'b0;
         m1         <= LT_R;
         m2         <= LT_R;
         m3         <= LT_R;
         m4         <= LT_R;
         grant      <= '0;
      end else begin
         state      <= state_n;
         cnt        <= cnt_n;
         cur        <= cur_n;
         ptr        <= ptr_n;
         emg_active <= emg_n;
         m1         <= lights_n[2:0];
         m2         <= lights_n[5:3];
         m3         <= lights_n[8:6];
         m4         <= lights_n[11:9];
         grant      <= grant_n;
      end
   end

endmodule
